// File: rtl/bpfcap_pkg.sv
// Types and constants shared by the capture-path blocks: Avalon-MM widths,
// the packet-memory responder state type and the stall LFSR seed.
package bpfcap_pkg;

  localparam int AVMM_DATA_W  = 32;
  localparam int AVMM_BURST_W = 16;

  localparam logic [15:0] PMR_LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } pmr_state_t;

endpackage

// File: rtl/pkt_mem_ram.sv
// Simple dual-port packet buffer: one write port, one registered read port.
// A same-address read and write in one cycle returns the new data.
module pkt_mem_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/pkt_mem_responder.sv
// Avalon-MM burst responder in front of the word-addressed packet buffer.
// Define PKT_MEM_BACKPRESSURE_EN to add pseudo-random waitrequest stalls.
module pkt_mem_responder
  import bpfcap_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          MAX_BURST = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             avs_address,
  input  logic                    avs_read,
  input  logic                    avs_write,
  input  logic [AVMM_DATA_W-1:0]  avs_writedata,
  input  logic [AVMM_BURST_W-1:0] avs_burstcount,
  output logic                    avs_waitrequest,
  output logic [AVMM_DATA_W-1:0]  avs_readdata,
  output logic                    avs_readdatavalid,
  output logic                    err_sticky
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AVMM_BURST_W-1:0] MAX_BC = AVMM_BURST_W'(MAX_BURST);

  pmr_state_t              state_reg;
  logic [AVMM_BURST_W-1:0] cnt_reg;
  logic [AW-1:0]           addr_reg;
  logic                    rdv_reg;
  logic                    ready_reg;
  logic                    err_reg;

  logic [AW-1:0]           cmd_index;
  logic [AVMM_BURST_W-1:0] eff_bc;
  logic                    bc_over;
  logic                    stall;
  logic                    ram_we;
  logic [AW-1:0]           ram_waddr;
  logic [AVMM_DATA_W-1:0]  ram_q;

  // Offset wraps modulo DEPTH by truncation of the word index.
  assign cmd_index = AW'((avs_address - BASE_ADDR) >> 2);

  always_comb begin
    bc_over = (avs_burstcount > MAX_BC);
    eff_bc  = avs_burstcount;
    if (avs_burstcount == '0) begin
      eff_bc = AVMM_BURST_W'(1);
    end else if (bc_over) begin
      eff_bc = MAX_BC;
    end
  end

`ifdef PKT_MEM_BACKPRESSURE_EN
  logic [15:0] lfsr_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr_reg <= PMR_LFSR_SEED;
    end else begin
      lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    end
  end

  assign stall = (lfsr_reg[1:0] == 2'b00) && ((state_reg == IDLE) || (state_reg == WR_BURST));
`else
  assign stall = 1'b0;
`endif

  // Held high while the final read beat is on the bus, so no command overlaps a read.
  assign avs_waitrequest = !ready_reg || (state_reg == RD_BURST) || rdv_reg || stall;

  assign ram_we    = avs_write && !avs_waitrequest && ((state_reg == IDLE) || (state_reg == WR_BURST));
  assign ram_waddr = (state_reg == IDLE) ? cmd_index : addr_reg;

  pkt_mem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (avs_writedata),
    .re    (state_reg == RD_BURST),
    .raddr (addr_reg),
    .rdata (ram_q)
  );

  assign avs_readdata      = rdv_reg ? ram_q : '0;
  assign avs_readdatavalid = rdv_reg;
  assign err_sticky        = err_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      rdv_reg   <= 1'b0;
      ready_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      ready_reg <= 1'b1;
      rdv_reg   <= (state_reg == RD_BURST);
      case (state_reg)
        IDLE: begin
          if (!avs_waitrequest && (avs_read || avs_write)) begin
            if (bc_over) begin
              err_reg <= 1'b1;
            end
            if (avs_write) begin
              if (avs_read) begin
                err_reg <= 1'b1;
              end
              if (eff_bc != AVMM_BURST_W'(1)) begin
                state_reg <= WR_BURST;
                cnt_reg   <= eff_bc - AVMM_BURST_W'(1);
                addr_reg  <= cmd_index + AW'(1);
              end
            end else begin
              state_reg <= RD_BURST;
              cnt_reg   <= eff_bc;
              addr_reg  <= cmd_index;
            end
          end
        end
        WR_BURST: begin
          if (avs_read) begin
            err_reg <= 1'b1;
          end
          if (avs_write && !avs_waitrequest) begin
            addr_reg <= addr_reg + AW'(1);
            cnt_reg  <= cnt_reg - AVMM_BURST_W'(1);
            if (cnt_reg == AVMM_BURST_W'(1)) begin
              state_reg <= IDLE;
            end
          end
        end
        RD_BURST: begin
          addr_reg <= addr_reg + AW'(1);
          cnt_reg  <= cnt_reg - AVMM_BURST_W'(1);
          if (cnt_reg == AVMM_BURST_W'(1)) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_mem_responder.sv
// Directed self-checking bench for pkt_mem_responder (default build, DEPTH=1024,
// BASE_ADDR=0, MAX_BURST=256).
module tb_pkt_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [15:0] avs_burstcount;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        err_sticky;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [31:0] rq[$];
  int          rc[$];

  pkt_mem_responder #(
    .DEPTH     (1024),
    .BASE_ADDR (32'h0),
    .MAX_BURST (256)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_burstcount    (avs_burstcount),
    .avs_waitrequest   (avs_waitrequest),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .err_sticky        (err_sticky)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Read beats are captured mid-cycle together with the cycle they appeared in.
  always @(negedge clk) begin
    if (avs_readdatavalid === 1'b1) begin
      rq.push_back(avs_readdata);
      rc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_cmd(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [15:0] bc, output int acc);
    int n;
    n = 0;
    avs_read = rd;
    avs_write = wr;
    avs_address = addr;
    avs_writedata = data;
    avs_burstcount = bc;
    while (avs_waitrequest !== 1'b0 && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) begin
      $display("FAIL cmd_accept timeout addr=%h got waitrequest=%b required 0", addr, avs_waitrequest);
      fails++;
      tests++;
    end
    acc = cyc;
    tick();
    avs_read = 1'b0;
    avs_write = 1'b0;
  endtask

  task automatic write_beat(input logic [31:0] data);
    int n;
    n = 0;
    avs_write = 1'b1;
    avs_writedata = data;
    while (avs_waitrequest !== 1'b0 && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) begin
      $display("FAIL beat_accept timeout data=%h got waitrequest=%b required 0", data, avs_waitrequest);
      fails++;
      tests++;
    end
    tick();
    avs_write = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int bound);
    int k;
    k = 0;
    while (rq.size() < n && k < bound) begin
      @(negedge clk);
      #1;
      k++;
    end
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    avs_address = '0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_writedata = '0;
    avs_burstcount = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (avs_waitrequest !== 1'b1) begin
      $display("FAIL reset_waitrequest got %b required 1", avs_waitrequest); fails++;
    end
    tests++;
    if (avs_readdatavalid !== 1'b0) begin
      $display("FAIL reset_readdatavalid got %b required 0", avs_readdatavalid); fails++;
    end
    tests++;
    if (avs_readdata !== 32'h0) begin
      $display("FAIL reset_readdata got %h required 00000000", avs_readdata); fails++;
    end
    tests++;
    if (err_sticky !== 1'b0) begin
      $display("FAIL reset_err got %b required 0", err_sticky); fails++;
    end
    reset = 1'b1;
    tick();
    tests++;
    if (avs_waitrequest !== 1'b0) begin
      $display("FAIL release_waitrequest got %b required 0", avs_waitrequest); fails++;
    end
    $display("[TB] reset: done");
  endtask

  task automatic test_single();
    int acc;
    bus_cmd(1'b0, 1'b1, 32'd8, 32'hDEADBEEF, 16'd1, acc);
    rq.delete(); rc.delete();
    bus_cmd(1'b1, 1'b0, 32'd8, 32'h0, 16'd1, acc);
    tests++;
    if (avs_waitrequest !== 1'b1) begin
      $display("FAIL single_busy got waitrequest=%b required 1", avs_waitrequest); fails++;
    end
    wait_beats(1, 20);
    tests++;
    if (rq.size() != 1) begin
      $display("FAIL single_count got %0d beats required 1", rq.size()); fails++;
    end
    tests++;
    if (rq.size() < 1 || rq[0] !== 32'hDEADBEEF) begin
      $display("FAIL single_data got %h required deadbeef", (rq.size() > 0) ? rq[0] : 32'h0); fails++;
    end
    tests++;
    if (rc.size() < 1 || rc[0] != acc + 2) begin
      $display("FAIL single_latency got cycle %0d required %0d", (rc.size() > 0) ? rc[0] : -1, acc + 2); fails++;
    end
    tests++;
    if (err_sticky !== 1'b0) begin
      $display("FAIL single_err got %b required 0", err_sticky); fails++;
    end
    $display("[TB] single write/read: data=%h", (rq.size() > 0) ? rq[0] : 32'h0);
  endtask

  task automatic test_wrap();
    int acc;
    logic [31:0] exp0[2];
    bus_cmd(1'b0, 1'b1, 32'd4088, 32'd1, 16'd4, acc);
    write_beat(32'd2);
    write_beat(32'd3);
    write_beat(32'd4);
    rq.delete(); rc.delete();
    bus_cmd(1'b1, 1'b0, 32'd4088, 32'h0, 16'd4, acc);
    wait_beats(4, 30);
    tests++;
    if (rq.size() != 4) begin
      $display("FAIL wrap_count got %0d beats required 4", rq.size()); fails++;
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (rq.size() <= i || rq[i] !== 32'(i + 1) || rc[i] != acc + 2 + i) begin
        $display("FAIL wrap_beat%0d got data=%h cycle=%0d required data=%h cycle=%0d", i,
                 (rq.size() > i) ? rq[i] : 32'h0, (rc.size() > i) ? rc[i] : -1, 32'(i + 1), acc + 2 + i);
        fails++;
      end
    end
    exp0[0] = 32'd3;
    exp0[1] = 32'd4;
    rq.delete(); rc.delete();
    bus_cmd(1'b1, 1'b0, 32'd0, 32'h0, 16'd2, acc);
    wait_beats(2, 20);
    for (int i = 0; i < 2; i++) begin
      tests++;
      if (rq.size() <= i || rq[i] !== exp0[i]) begin
        $display("FAIL wrap_word%0d got %h required %h", i, (rq.size() > i) ? rq[i] : 32'h0, exp0[i]);
        fails++;
      end
    end
    $display("[TB] wrap burst: %0d beats read back from word 0", rq.size());
  endtask

  task automatic test_bubble();
    int acc;
    logic [31:0] exp_w[10];
    bus_cmd(1'b0, 1'b1, 32'd396, 32'h55, 16'd1, acc);
    bus_cmd(1'b0, 1'b1, 32'd432, 32'hAA, 16'd1, acc);
    bus_cmd(1'b0, 1'b1, 32'd400, 32'h100, 16'd8, acc);
    write_beat(32'h101);
    write_beat(32'h102);
    avs_writedata = 32'hBAD0BAD0;
    tick();
    tick();
    for (int i = 3; i < 8; i++) write_beat(32'(32'h100 + i));
    exp_w[0] = 32'h55;
    for (int i = 1; i < 9; i++) exp_w[i] = 32'(32'h100 + i - 1);
    exp_w[9] = 32'hAA;
    rq.delete(); rc.delete();
    bus_cmd(1'b1, 1'b0, 32'd396, 32'h0, 16'd10, acc);
    wait_beats(10, 40);
    tests++;
    if (rq.size() != 10 || rc[0] != acc + 2) begin
      $display("FAIL bubble_readback got %0d beats first cycle %0d required 10 beats at %0d",
               rq.size(), (rc.size() > 0) ? rc[0] : -1, acc + 2);
      fails++;
    end
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (rq.size() <= i || rq[i] !== exp_w[i]) begin
        $display("FAIL bubble_word%0d got %h required %h", 99 + i, (rq.size() > i) ? rq[i] : 32'h0, exp_w[i]);
        fails++;
      end
    end
    tests++;
    if (err_sticky !== 1'b0) begin
      $display("FAIL bubble_err got %b required 0", err_sticky); fails++;
    end
    $display("[TB] bubble burst: %0d words checked", rq.size());
  endtask

  task automatic test_bc0();
    int acc;
    rq.delete(); rc.delete();
    bus_cmd(1'b1, 1'b0, 32'd8, 32'h0, 16'd0, acc);
    wait_beats(1, 20);
    tests++;
    if (rq.size() != 1 || rq[0] !== 32'hDEADBEEF) begin
      $display("FAIL bc0_count got %0d beats required 1 with data deadbeef", rq.size()); fails++;
    end
    tests++;
    if (err_sticky !== 1'b0) begin
      $display("FAIL bc0_err got %b required 0", err_sticky); fails++;
    end
    $display("[TB] burstcount 0 read: %0d beat(s)", rq.size());
  endtask

  task automatic test_conflict();
    int acc;
    rq.delete(); rc.delete();
    bus_cmd(1'b1, 1'b1, 32'd800, 32'h77, 16'd1, acc);
    repeat (6) tick();
    tests++;
    if (rq.size() != 0) begin
      $display("FAIL conflict_no_read got %0d beats required 0", rq.size()); fails++;
    end
    tests++;
    if (err_sticky !== 1'b1) begin
      $display("FAIL conflict_err got %b required 1", err_sticky); fails++;
    end
    bus_cmd(1'b1, 1'b0, 32'd800, 32'h0, 16'd1, acc);
    wait_beats(1, 20);
    tests++;
    if (rq.size() != 1 || rq[0] !== 32'h77) begin
      $display("FAIL conflict_write got %h (%0d beats) required 00000077", (rq.size() > 0) ? rq[0] : 32'h0, rq.size());
      fails++;
    end
    $display("[TB] read+write conflict: err=%b", err_sticky);
  endtask

  task automatic test_reset_mid();
    int acc;
    int k;
    rq.delete(); rc.delete();
    bus_cmd(1'b1, 1'b0, 32'd396, 32'h0, 16'd16, acc);
    k = 0;
    while (rq.size() < 3 && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (avs_readdatavalid !== 1'b0) begin
      $display("FAIL midreset_rdv got %b required 0", avs_readdatavalid); fails++;
    end
    tests++;
    if (avs_waitrequest !== 1'b1) begin
      $display("FAIL midreset_waitrequest got %b required 1", avs_waitrequest); fails++;
    end
    tests++;
    if (err_sticky !== 1'b0) begin
      $display("FAIL midreset_err got %b required 0", err_sticky); fails++;
    end
    reset = 1'b1;
    tick();
    tests++;
    if (avs_waitrequest !== 1'b0) begin
      $display("FAIL midreset_release got waitrequest=%b required 0", avs_waitrequest); fails++;
    end
    repeat (4) tick();
    tests++;
    if (rq.size() != 3) begin
      $display("FAIL midreset_beats got %0d beats required 3", rq.size()); fails++;
    end
    rq.delete(); rc.delete();
    bus_cmd(1'b1, 1'b0, 32'd400, 32'h0, 16'd1, acc);
    wait_beats(1, 20);
    tests++;
    if (rq.size() != 1 || rq[0] !== 32'h100 || rc[0] != acc + 2) begin
      $display("FAIL midreset_newread got %h (%0d beats) required 00000100", (rq.size() > 0) ? rq[0] : 32'h0, rq.size());
      fails++;
    end
    $display("[TB] reset mid-burst: recovered read=%h", (rq.size() > 0) ? rq[0] : 32'h0);
  endtask

  task automatic test_clamp();
    int acc;
    rq.delete(); rc.delete();
    bus_cmd(1'b1, 1'b0, 32'd0, 32'h0, 16'd300, acc);
    wait_beats(256, 400);
    tests++;
    if (rq.size() != 256) begin
      $display("FAIL clamp_count got %0d beats required 256", rq.size()); fails++;
    end
    tests++;
    if (rq.size() < 1 || rq[0] !== 32'd3) begin
      $display("FAIL clamp_first got %h required 00000003", (rq.size() > 0) ? rq[0] : 32'h0); fails++;
    end
    tests++;
    if (err_sticky !== 1'b1) begin
      $display("FAIL clamp_err got %b required 1", err_sticky); fails++;
    end
    $display("[TB] burstcount 300 read: %0d beats err=%b", rq.size(), err_sticky);
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_bubble();
    test_bc0();
    test_conflict();
    test_reset_mid();
    test_clamp();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pkt_mem_responder.md
# pkt_mem_responder

Avalon-MM burst responder fronting a word-addressed on-chip packet buffer; it is the memory-side counterpart of the capture datapath's burst read host and burst write host. It accepts single and burst reads/writes, returns read data with `readdatavalid`, and throttles with `waitrequest`. It is used as the packet-buffer endpoint in standalone capture builds and as the memory endpoint in capture-path test benches.

## Interface
- `DEPTH`, 1024: buffer size in 32-bit words, power of two.
- `BASE_ADDR`, 32'h0: byte address mapped to word 0.
- `MAX_BURST`, 256: largest legal burstcount.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-low.
- `avs_address` in 32: byte address, word aligned; bits [1:0] ignored.
- `avs_read` in 1: read command.
- `avs_write` in 1: write command/beat.
- `avs_writedata` in 32: write beat data.
- `avs_burstcount` in 16: beats; sampled on the first beat only.
- `avs_waitrequest` out 1: command/beat not accepted this cycle.
- `avs_readdata` out 32: read beat data.
- `avs_readdatavalid` out 1: `avs_readdata` is valid.
- `err_sticky` out 1: protocol violation seen; cleared only by reset.

## Operation
- Word index = ((`avs_address` − `BASE_ADDR`) >> 2) mod `DEPTH`. The index increments by 1 per beat and wraps from `DEPTH`−1 to 0 with no error.
- Effective burst count: 0 is treated as 1. Values above `MAX_BURST` are clamped to `MAX_BURST` and set `err_sticky`.
- States:
  - IDLE: accepts a command when the command is asserted and `avs_waitrequest`=0.
  - WR_BURST: accepts one beat per cycle while `avs_write`=1 and `avs_waitrequest`=0. `avs_write`=0 is a host bubble; it holds state and writes nothing.
  - RD_BURST: streams beats.
- Transitions:
  - IDLE→WR_BURST on an accepted write with count>1. The first beat is written at acceptance.
  - A count=1 write stays in IDLE.
  - WR_BURST→IDLE when the last beat is accepted.
  - IDLE→RD_BURST on an accepted read.
  - RD_BURST→IDLE in the cycle the last `readdatavalid` is driven.
- `avs_read` and `avs_write` both high in IDLE: write wins, read is dropped, `err_sticky` is set.
- `avs_read` during WR_BURST: ignored, `err_sticky` is set.
- The beat counter is 16 bits and counts down the remaining beats.

## Timing
- Reset values: `avs_waitrequest`=1, `avs_readdatavalid`=0, `avs_readdata`=0, `err_sticky`=0, state IDLE, counters 0. RAM contents are not cleared.
- `avs_waitrequest` drops the first cycle after reset deasserts.
- Read latency: command accepted at cycle T gives the first `readdatavalid` at T+2. Subsequent beats follow one per cycle with no gaps. The last beat is at T+1+N.
- `avs_waitrequest`=1 from T+1 through T+1+N. The next command can be accepted at T+2+N. There is no command pipelining.
- Writes: data is in the RAM the cycle after acceptance. A read accepted the cycle after a write's last beat returns the new data (no read-before-write hazard).
- Reset asserted mid-burst: state returns to IDLE next edge. Remaining beats are abandoned and `readdatavalid` drops immediately.

## Configuration
- `PKT_MEM_BACKPRESSURE_EN` defined:
  - A 16-bit LFSR (seed 16'hACE1, advances every cycle) forces `avs_waitrequest`=1 whenever LFSR[1:0]==2'b00, in IDLE and WR_BURST.
  - Read-beat spacing is unaffected.
  - Exercises host stall handling.
- Not defined: no LFSR logic; `avs_waitrequest` behaves exactly as described in Timing.

## Structure
- Shared package `bpfcap_pkg`:
  - state enum `pmr_state_t` (IDLE, WR_BURST, RD_BURST);
  - `AVMM_DATA_W`=32, `AVMM_BURST_W`=16;
  - LFSR seed constant.
- Sub-module `pkt_mem_ram`: simple dual-port RAM, `DEPTH`×32, one write port, one registered read port, new-data-on-collision. Infers block RAM.

## Test plan
- Single write 32'hDEADBEEF at `BASE_ADDR`+8, then a single read at the same address → `readdatavalid` exactly 2 cycles after read acceptance, data 32'hDEADBEEF, `err_sticky`=0.
- Write burst of 4 at word `DEPTH`−2 with data 1..4, then read burst of 4 from the same address → data 1,2,3,4 on 4 consecutive cycles. Words 0 and 1 hold 3 and 4 (wrap-around).
- Write burst of 8 with `avs_write` deasserted for 2 cycles mid-burst → 8 words written, no extra writes, return to IDLE after beat 8.
- Burstcount 0 read → exactly one `readdatavalid`. Burstcount 300 read → 256 beats and `err_sticky`=1.
- `avs_read`=`avs_write`=1 in IDLE → write performed, no `readdatavalid`, `err_sticky`=1.
- Reset pulsed at beat 3 of a 16-beat read → `readdatavalid` low the cycle after the reset edge, `avs_waitrequest`=1 during reset, a new read accepted after release returns correct data.
